mips_io_bridge: RTL and testbench
=================================

MIPS_IO_BRIDGE -- requirements
Module: mips_io_bridge

Interface
REQ-001 Parameter CLK_DIV, default 434, clk cycles per UART bit (range 2..65535).
REQ-002 clk  input  1  main clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_ren, mem_wen  input  1 each  core memory read/write enables.
REQ-005 mem_addr  input  32  core byte address.
REQ-006 mem_dout  input  32  core write data.
REQ-007 mem_din  output  32  read data to core.
REQ-008 ram_ren, ram_wen  output  1 each  data-RAM read/write enables.
REQ-009 ram_addr, ram_dout  output  32 each  data-RAM address and write data.
REQ-010 ram_din  input  32  data-RAM read data.
REQ-011 switch  input  16  board switches; led  output  16  board LEDs.
REQ-012 uart_tx  output  1  serial transmit line, 8N1, idle high.
REQ-013 timer_irq  output  1  sticky timer-match flag.

Function
REQ-014 IO region is mem_addr[31:16]==16'hFFFF; all other addresses are RAM region.
REQ-015 RAM region: ram_* equal mem_*, and mem_din=ram_din, all combinationally. In IO region, ram_ren=ram_wen=0.
REQ-016 IO reads are combinational, with zero added latency. IO writes take effect at the next rising edge.
REQ-017 IO map by mem_addr[7:0]:
- 0x00 LED (R/W, bits[15:0]).
- 0x04 SWITCH (RO, zero-extended).
- 0x08 COUNT (R/W).
- 0x0C COMPARE (R/W).
- 0x10 CTRL (bit0 enable R/W; writing bit1=1 clears timer_irq; bit1 reads 0).
- 0x14 TXDATA (WO, bits[7:0]).
- 0x18 STATUS (RO: bit0 fifo_empty, bit1 fifo_full, bits[4:2] fifo count, bit5 overflow, bit6 tx_busy; a write of bit5=1 clears overflow).
REQ-018 Unmapped IO offsets read 0; writes to them and to RO registers are ignored.
REQ-019 COUNT increments by 1 each cycle while enable=1 and wraps from 0xFFFFFFFF to 0.
REQ-020 A COUNT write in the same cycle as an increment takes priority: the written value is loaded and no increment is applied.
REQ-021 timer_irq sets on the edge after a cycle where enable=1 and COUNT==COMPARE. A set condition and a clear write in the same cycle leave timer_irq=1.
REQ-022 TX FIFO depth is 4. A TXDATA write pushes one byte.
REQ-023 A TXDATA write while full is dropped and sets overflow, except when a pop occurs in the same cycle; in that case the write is accepted.
REQ-024 Serializer FSM states are IDLE, START, DATA, STOP.
- IDLE->START when the FIFO is non-empty, popping the head byte.
- START drives 0 for CLK_DIV cycles.
- DATA shifts 8 bits LSB-first, CLK_DIV cycles each.
- STOP drives 1 for CLK_DIV cycles, then goes to START if the FIFO is non-empty, otherwise IDLE.
REQ-025 Latency: a TXDATA write at edge N into an empty FIFO with the FSM in IDLE gives uart_tx=0 from edge N+1.
REQ-026 tx_busy=1 in any state other than IDLE.
REQ-027 mem_ren and mem_wen asserted together in the IO region perform the write, and mem_din shows the pre-write value.

Reset
REQ-028 On rst=1 at a rising edge, the block SHALL reset as follows:
- LED, COUNT, COMPARE and enable to 0.
- timer_irq and overflow to 0.
- FIFO emptied, with pointers and count set to 0.
- FSM to IDLE, with uart_tx=1.
REQ-029 Reset mid-frame aborts the frame immediately. Pending FIFO bytes are discarded.

Configuration
REQ-030 Macro IO_UART_EN: when defined, the TX FIFO, the serializer and the TXDATA/STATUS registers are present.
REQ-031 Without IO_UART_EN:
- uart_tx is constant 1.
- TXDATA writes are ignored.
- STATUS reads 0x00000001.
- No FIFO or serializer logic is synthesised.

Verification
REQ-032 Write 0x00005A5A to 0xFFFF0000, then read it back -> led=16'h5A5A and mem_din=0x00005A5A. Access to 0x00000100 -> ram_wen=1, ram_addr=0x100, and the LED register is unchanged.
REQ-033 Write COMPARE=5, then write CTRL=1 with COUNT=0 -> timer_irq rises on the 7th edge after the CTRL write. Writing CTRL=3 then clears it.
REQ-034 Write COUNT=0xFFFFFFFE with enable=1 -> two edges later COUNT reads 0x00000000.
REQ-035 CLK_DIV=4, write TXDATA=0xA5 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 cycles.
REQ-036 Six back-to-back TXDATA writes while the FSM is in IDLE -> the first byte is popped and the next 4 are queued, so the 6th write is dropped. STATUS then reads full=1, count=4, overflow=1, busy=1.
REQ-037 Assert rst mid-DATA -> uart_tx=1 and STATUS=0x00000001 on the next cycle.

Source files
------------

// File: rtl/mips_io_bridge.sv
// mips_io_bridge: splits the core's data bus into a RAM region and a small
// memory-mapped IO block at 0xFFFF_xxxx (LEDs, switches, a free-running timer
// with compare, and an optional 8N1 UART transmitter behind a 4-deep FIFO).
// Build option: define IO_UART_EN to include the TX FIFO, the serializer and
// the TXDATA/STATUS registers; without it uart_tx idles high and STATUS reads 1.
//
// Bus protocol: there is no valid/ready handshake. mem_ren/mem_wen are
// single-cycle strobes that are always accepted. Reads return data
// combinationally in the same cycle. Writes commit on the rising edge that
// ends the cycle. When both strobes are set, the read shows the value held
// before that write.
module mips_io_bridge #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_dout,
  input  logic [31:0] ram_din,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic        uart_tx,
  output logic        timer_irq
);

  // The bit-period divider counts in 16 bits, so CLK_DIV must fit in that range.
  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("mips_io_bridge: CLK_DIV must be in 2..65535");
  end

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_SWITCH = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_CMP    = 8'h0C;
  localparam logic [7:0] OFF_CTRL   = 8'h10;
  localparam logic [7:0] OFF_TXDATA = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;

  logic        io_sel;
  logic        io_we;
  logic        we_led;
  logic        we_count;
  logic        we_cmp;
  logic        we_ctrl;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        enable_q;
  logic [31:0] status_word;
  logic [31:0] io_rdata;

  assign io_sel   = (mem_addr[31:16] == 16'hFFFF);
  assign io_we    = io_sel & mem_wen;
  assign we_led   = io_we && (mem_addr[7:0] == OFF_LED);
  assign we_count = io_we && (mem_addr[7:0] == OFF_COUNT);
  assign we_cmp   = io_we && (mem_addr[7:0] == OFF_CMP);
  assign we_ctrl  = io_we && (mem_addr[7:0] == OFF_CTRL);

  // The RAM side sees the core bus directly. Only the enables are gated by region.
  assign ram_ren  = mem_ren & ~io_sel;
  assign ram_wen  = mem_wen & ~io_sel;
  assign ram_addr = mem_addr;
  assign ram_dout = mem_dout;
  assign mem_din  = io_sel ? io_rdata : ram_din;

  // IO read mux. Write-only and unmapped offsets read as zero.
  always_comb begin
    io_rdata = '0;
    case (mem_addr[7:0])
      OFF_LED:    io_rdata = {16'h0000, led};
      OFF_SWITCH: io_rdata = {16'h0000, switch};
      OFF_COUNT:  io_rdata = count_q;
      OFF_CMP:    io_rdata = compare_q;
      OFF_CTRL:   io_rdata = {31'h0, enable_q};
      OFF_STATUS: io_rdata = status_word;
      default:    io_rdata = '0;
    endcase
  end

  // LED, timer and sticky compare flag. A COUNT write overrides the increment,
  // and a compare hit overrides a clear request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      count_q   <= '0;
      compare_q <= '0;
      enable_q  <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      if (we_led) led <= mem_dout[15:0];
      if (we_cmp) compare_q <= mem_dout;
      if (we_count) count_q <= mem_dout;
      else if (enable_q) count_q <= count_q + 32'd1;
      if (we_ctrl) enable_q <= mem_dout[0];
      if (enable_q && (count_q == compare_q)) timer_irq <= 1'b1;
      else if (we_ctrl && mem_dout[1]) timer_irq <= 1'b0;
    end
  end

`ifdef IO_UART_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  // Serializer state stays visible by name so checkers can bind to it.
  tx_state_t   tx_state;
  logic [15:0] div_q;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic        we_tx;
  logic        we_status;
  logic        pop;
  logic        push;
  logic        tx_busy;

  assign we_tx      = io_we && (mem_addr[7:0] == OFF_TXDATA);
  assign we_status  = io_we && (mem_addr[7:0] == OFF_STATUS);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign fifo_full  = (fifo_cnt == 3'd4);
  assign tx_busy    = (tx_state != S_IDLE);
  // The serializer takes a byte when it is idle, or at the end of a stop bit.
  assign pop  = !fifo_empty &&
                ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (div_q == DIV_LAST)));
  // A write to a full FIFO still fits if the serializer drains a slot in the same cycle.
  assign push = we_tx && (!fifo_full || pop);
  assign status_word = {25'h0, tx_busy, overflow, fifo_cnt, fifo_full, fifo_empty};

  // FIFO storage. The contents need no reset because the pointers and count gate them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout[7:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag, where a set wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (we_tx && !push) overflow <= 1'b1;
      else if (we_status && mem_dout[5]) overflow <= 1'b0;
    end
  end

  // 8N1 serializer FSM with a registered line output. Each bit lasts CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      uart_tx  <= 1'b1;
      div_q    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (pop) begin
            tx_state <= S_START;
            uart_tx  <= 1'b0;
            div_q    <= '0;
            shreg    <= fifo_mem[rd_ptr];
          end
        end
        S_START: begin
          if (div_q == DIV_LAST) begin
            div_q    <= '0;
            tx_state <= S_DATA;
            bit_idx  <= '0;
            uart_tx  <= shreg[0];
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_DATA: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_idx == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_STOP: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (pop) begin
              tx_state <= S_START;
              uart_tx  <= 1'b0;
              shreg    <= fifo_mem[rd_ptr];
            end else begin
              tx_state <= S_IDLE;
              uart_tx  <= 1'b1;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        default: begin
          tx_state <= S_IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end
`else
  // Without the UART, the line idles high and STATUS always reports an empty FIFO.
  assign uart_tx     = 1'b1;
  assign status_word = 32'h0000_0001;
`endif

endmodule

// File: tb/tb_mips_io_bridge.sv
// Directed bench for mips_io_bridge: bus decode, LED/switch registers, timer
// with compare flag, counter wrap, and (with IO_UART_EN) the TX FIFO and frame.
module tb_mips_io_bridge;

  localparam int CLK_DIV = 4;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_SWITCH = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP    = 32'hFFFF_000C;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0010;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0014;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0018;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_001C;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_dout;
  logic [31:0] ram_din;
  logic [15:0] switch;
  logic [15:0] led;
  logic        uart_tx;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  mips_io_bridge #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .switch    (switch),
    .led       (led),
    .uart_tx   (uart_tx),
    .timer_irq (timer_irq)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle write strobe, committed by the next rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_addr = addr;
    mem_dout = data;
    mem_ren  = 1'b0;
    mem_wen  = 1'b1;
    @(posedge clk);
    #1;
    mem_wen  = 1'b0;
  endtask

  // Combinational read, sampled mid-cycle.
  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    mem_wen  = 1'b0;
    mem_ren  = 1'b1;
    #1;
    check(tag, mem_din, exp);
    mem_ren  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_led"}, {16'h0, led}, 32'h0);
    check({tag, "_irq"}, {31'h0, timer_irq}, 32'h0);
    check({tag, "_tx"}, {31'h0, uart_tx}, 32'h1);
    bus_read({tag, "_count"}, A_COUNT, 32'h0);
    bus_read({tag, "_cmp"}, A_CMP, 32'h0);
    bus_read({tag, "_ctrl"}, A_CTRL, 32'h0);
    bus_read({tag, "_status"}, A_STATUS, 32'h1);
  endtask

`ifdef IO_UART_EN
  // 0xA5 framed 8N1, LSB first: start, 1,0,1,0,0,1,0,1, stop.
  logic exp_frame [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
    rst      = 1'b1;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    ram_din  = 32'hCAFE_F00D;
    switch   = 16'hBEEF;
    tick(2);
    rst = 1'b0;
    check_reset_state("reset");

    // LED write and readback
    bus_write(A_LED, 32'h0000_5A5A);
    check("led_out", {16'h0, led}, 32'h0000_5A5A);
    bus_read("led_read", A_LED, 32'h0000_5A5A);

    // RAM-region write passes through, LED untouched
    mem_addr = 32'h0000_0100;
    mem_dout = 32'hDEAD_BEEF;
    mem_wen  = 1'b1;
    #1;
    check("ram_wen", {31'h0, ram_wen}, 32'h1);
    check("ram_ren_on_write", {31'h0, ram_ren}, 32'h0);
    check("ram_addr", ram_addr, 32'h0000_0100);
    check("ram_dout", ram_dout, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
    check("led_after_ram_wr", {16'h0, led}, 32'h0000_5A5A);

    // RAM-region read returns ram_din
    mem_addr = 32'h0000_0200;
    mem_ren  = 1'b1;
    #1;
    check("ram_ren", {31'h0, ram_ren}, 32'h1);
    check("ram_read", mem_din, 32'hCAFE_F00D);
    // IO read keeps RAM disabled
    mem_addr = A_SWITCH;
    #1;
    check("ram_ren_io", {31'h0, ram_ren}, 32'h0);
    check("switch_read", mem_din, 32'h0000_BEEF);
    mem_ren = 1'b0;

    // Writes to RO and unmapped offsets are ignored
    bus_write(A_SWITCH, 32'h0000_1234);
    bus_read("switch_ro", A_SWITCH, 32'h0000_BEEF);
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    bus_read("unmapped_read", A_UNMAP, 32'h0);
    check("led_after_unmap", {16'h0, led}, 32'h0000_5A5A);

    // Simultaneous read and write shows the pre-write value
    mem_addr = A_LED;
    mem_dout = 32'h0000_1111;
    mem_ren  = 1'b1;
    mem_wen  = 1'b1;
    #1;
    check("rw_old_value", mem_din, 32'h0000_5A5A);
    check("rw_ram_wen", {31'h0, ram_wen}, 32'h0);
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    check("rw_new_led", {16'h0, led}, 32'h0000_1111);

    // Timer: COMPARE=5, enable with COUNT=0. Counting the CTRL write edge as the
    // first, the flag is set on the 7th.
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, 32'd1);
    check("irq_edge1", {31'h0, timer_irq}, 32'h0);
    for (int i = 2; i <= 6; i++) begin
      tick(1);
      check($sformatf("irq_edge%0d", i), {31'h0, timer_irq}, 32'h0);
    end
    tick(1);
    check("irq_edge7", {31'h0, timer_irq}, 32'h1);
    bus_read("count_at_irq", A_COUNT, 32'd6);
    bus_write(A_CTRL, 32'd3);
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);
    bus_read("ctrl_bit1_reads0", A_CTRL, 32'h1);

    // COUNT write beats increment; a compare hit beats a clear in the same cycle
    bus_write(A_CMP, 32'h0000_0101);
    bus_write(A_COUNT, 32'h0000_0100);
    bus_read("count_load_prio", A_COUNT, 32'h0000_0100);
    tick(1);
    bus_read("count_inc", A_COUNT, 32'h0000_0101);
    check("irq_before_race", {31'h0, timer_irq}, 32'h0);
    bus_write(A_CTRL, 32'd3);
    check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
    bus_write(A_CTRL, 32'd3);
    check("irq_clear2", {31'h0, timer_irq}, 32'h0);

    // Wrap
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_read("wrap0", A_COUNT, 32'hFFFF_FFFE);
    tick(1);
    bus_read("wrap1", A_COUNT, 32'hFFFF_FFFF);
    tick(1);
    bus_read("wrap2", A_COUNT, 32'h0000_0000);

    // Disable freezes COUNT (the edge of the disabling write still increments)
    bus_write(A_CTRL, 32'd0);
    tick(3);
    bus_read("count_frozen", A_COUNT, 32'd1);
    bus_read("ctrl_off", A_CTRL, 32'd0);

`ifdef IO_UART_EN
    // Single frame 0xA5; the line falls one edge after the write
    bus_write(A_TXDATA, 32'h0000_00A5);
    check("tx_idle_at_write", {31'h0, uart_tx}, 32'h1);
    bus_read("status_one_queued", A_STATUS, 32'h0000_0004);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        tick(1);
        check($sformatf("tx_bit%0d_cyc%0d", b, c), {31'h0, uart_tx}, {31'h0, exp_frame[b]});
      end
    end
    tick(1);
    bus_read("status_after_frame", A_STATUS, 32'h0000_0001);

    // Six back-to-back writes: one popped, four queued, sixth dropped
    for (int k = 0; k < 6; k++) bus_write(A_TXDATA, 32'h11 + k);
    bus_read("status_overflow", A_STATUS, 32'h0000_0072);
    bus_write(A_STATUS, 32'h0000_0020);
    bus_read("status_ovf_clear", A_STATUS, 32'h0000_0052);
    tick(3);
`else
    // TXDATA is ignored and the line stays idle
    bus_write(A_TXDATA, 32'h0000_00A5);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      check($sformatf("tx_stays_high%0d", c), {31'h0, uart_tx}, 32'h1);
    end
    bus_read("status_no_uart", A_STATUS, 32'h0000_0001);
`endif

    // Reset mid-run (mid-DATA when the UART is built in)
    bus_write(A_LED, 32'h0000_00FF);
    bus_write(A_CTRL, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_state("midrst");
    tick(4 * CLK_DIV);
    check("tx_after_rst_idle", {31'h0, uart_tx}, 32'h1);
    bus_read("status_after_rst_idle", A_STATUS, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
